// File: rtl/descriptor_to_axis_mc.sv
// Round-robin multi-channel descriptor to AXI-Stream packet generator.
// Define DESC_TO_AXIS_STATS_EN to add the pkt_cnt_o / byte_cnt_o statistics ports.
module descriptor_to_axis_mc #(
  parameter int NUM_CH      = 4,
  parameter int ID_WIDTH    = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int LEN_WIDTH   = 16,
  parameter int PAUSE_WIDTH = 32,
  parameter int TKEEP_WIDTH = DATA_WIDTH / 8,
  parameter int DESC_W      = 2 + ID_WIDTH + PAUSE_WIDTH + LEN_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DATA_WIDTH-1:0]    psrand_data_i,
  input  logic [NUM_CH*DESC_W-1:0] desc_data_i,
  input  logic [NUM_CH-1:0]        desc_valid_i,
  output logic [NUM_CH-1:0]        desc_ready_o,
  output logic [ID_WIDTH-1:0]      m_axis_tid_o,
  output logic [DATA_WIDTH-1:0]    m_axis_tdata_o,
  output logic [TKEEP_WIDTH-1:0]   m_axis_tkeep_o,
  output logic                     m_axis_tlast_o,
  output logic                     m_axis_tvalid_o,
  input  logic                     m_axis_tready_i,
  output logic                     busy_o
`ifdef DESC_TO_AXIS_STATS_EN
  ,
  output logic [31:0]              pkt_cnt_o,
  output logic [47:0]              byte_cnt_o
`endif
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [LEN_WIDTH-1:0] TK_L = LEN_WIDTH'(TKEEP_WIDTH);

  typedef enum logic [1:0] {IDLE, SEND, DRAIN, PAUSE} state_t;
  state_t state_q, state_d;

  logic [CH_W-1:0]        rr_q, grant_idx, cand;
  logic                   grant_valid;
  logic [DESC_W-1:0]      desc_sel;
  logic [LEN_WIDTH-1:0]   sel_len;
  logic [PAUSE_WIDTH-1:0] sel_pause;
  logic [ID_WIDTH-1:0]    sel_id;
  logic [1:0]             sel_mode;

  logic [1:0]             mode_q;
  logic [ID_WIDTH-1:0]    id_q;
  logic [PAUSE_WIDTH-1:0] pause_q, pause_cnt_q;
  logic [LEN_WIDTH-1:0]   rem_q, beat_q;
  logic [7:0]             byte_base_q;

  logic                   accept, load_beat, last_beat, out_hs;
  logic [TKEEP_WIDTH-1:0] last_keep;
  logic [DATA_WIDTH-1:0]  beat_data;

  // Search starts at the round-robin pointer so the last served channel goes to the back.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cand = CH_W'((int'(rr_q) + i) % NUM_CH);
      if (!grant_valid && desc_valid_i[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign desc_sel  = desc_data_i[int'(grant_idx)*DESC_W +: DESC_W];
  assign sel_len   = desc_sel[LEN_WIDTH-1:0];
  assign sel_pause = desc_sel[LEN_WIDTH +: PAUSE_WIDTH];
  assign sel_id    = desc_sel[LEN_WIDTH+PAUSE_WIDTH +: ID_WIDTH];
  assign sel_mode  = desc_sel[DESC_W-1 -: 2];

  always_comb begin
    desc_ready_o = '0;
    if (state_q == IDLE && grant_valid && reset_n)
      desc_ready_o[grant_idx] = 1'b1;
  end

  assign accept    = (state_q == IDLE) && grant_valid;
  assign out_hs    = m_axis_tvalid_o && m_axis_tready_i;
  assign load_beat = (state_q == SEND) && (!m_axis_tvalid_o || m_axis_tready_i);
  assign last_beat = (rem_q <= TK_L);
  assign busy_o    = (state_q != IDLE);

  // rem_q counts bytes still to send, so the final beat keeps exactly rem_q bytes.
  always_comb begin
    last_keep = '0;
    for (int k = 0; k < TKEEP_WIDTH; k++)
      last_keep[k] = (rem_q > LEN_WIDTH'(k));
  end

  always_comb begin
    beat_data = '0;
    case (mode_q)
      2'd0: beat_data = psrand_data_i;
      2'd1: beat_data = DATA_WIDTH'(beat_q);
      2'd2: for (int k = 0; k < TKEEP_WIDTH; k++)
              beat_data[8*k +: 8] = byte_base_q + 8'(k);
      default: beat_data = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_valid) begin
                 if (sel_len != '0)        state_d = SEND;
                 else if (sel_pause != '0) state_d = PAUSE;
               end
      SEND:    if (load_beat && last_beat) state_d = DRAIN;
      DRAIN:   if (out_hs) state_d = (pause_q != '0) ? PAUSE : IDLE;
      PAUSE:   if (pause_cnt_q <= PAUSE_WIDTH'(1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_q            <= '0;
      mode_q          <= '0;
      id_q            <= '0;
      pause_q         <= '0;
      pause_cnt_q     <= '0;
      rem_q           <= '0;
      beat_q          <= '0;
      byte_base_q     <= '0;
      m_axis_tvalid_o <= 1'b0;
      m_axis_tlast_o  <= 1'b0;
      m_axis_tdata_o  <= '0;
      m_axis_tkeep_o  <= '0;
      m_axis_tid_o    <= '0;
    end else begin
      if (accept) begin
        mode_q      <= sel_mode;
        id_q        <= sel_id;
        pause_q     <= sel_pause;
        rem_q       <= sel_len;
        beat_q      <= '0;
        byte_base_q <= '0;
        rr_q        <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
        if (sel_len == '0) pause_cnt_q <= sel_pause;
      end
      if (load_beat) begin
        m_axis_tvalid_o <= 1'b1;
        m_axis_tid_o    <= id_q;
        m_axis_tdata_o  <= beat_data;
        m_axis_tlast_o  <= last_beat;
        m_axis_tkeep_o  <= last_beat ? last_keep : '1;
        rem_q           <= rem_q - TK_L;
        beat_q          <= beat_q + 1'b1;
        byte_base_q     <= byte_base_q + 8'(TKEEP_WIDTH);
      end else if (state_q == DRAIN && out_hs) begin
        m_axis_tvalid_o <= 1'b0;
        pause_cnt_q     <= pause_q;
      end
      if (state_q == PAUSE) pause_cnt_q <= pause_cnt_q - 1'b1;
    end
  end

`ifdef DESC_TO_AXIS_STATS_EN
  logic [47:0] keep_cnt;

  always_comb begin
    keep_cnt = '0;
    for (int k = 0; k < TKEEP_WIDTH; k++)
      keep_cnt = keep_cnt + 48'(m_axis_tkeep_o[k]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_cnt_o  <= '0;
      byte_cnt_o <= '0;
    end else if (out_hs) begin
      byte_cnt_o <= byte_cnt_o + keep_cnt;
      if (m_axis_tlast_o) pkt_cnt_o <= pkt_cnt_o + 32'd1;
    end
  end
`endif

endmodule
